// File: rtl/ser_pkg.sv
// Shared types for the serializator/deserializator link: default word width and counter types.
package ser_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = $clog2(DATA_W_DEF);

    typedef logic [DATA_W_DEF-1:0] ser_word_t;
    typedef logic [CNT_W-1:0]      ser_cnt_t;
endpackage

// File: rtl/deserializator.sv
// Collects an MSB-first serial stream (one bit per valid cycle, gaps allowed) into DATA_W-bit words
// and flags each completed word with a one-cycle registered pulse.
module deserializator
    import ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic              deser_data_val_o
);
    localparam int LCNT_W = $clog2(DATA_W);
    localparam logic [LCNT_W-1:0] CNT_LAST = LCNT_W'(DATA_W - 1);

    logic [LCNT_W-1:0] cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              last_bit;

    // Completion is decided on the incoming bit, so the word is assembled from shift_q plus ser_data_i.
    assign last_bit = ser_data_val_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else if (ser_data_val_i) begin
            if (last_bit) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shift_q <= '0;
        end else if (ser_data_val_i) begin
            shift_q <= {shift_q[DATA_W-2:0], ser_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            deser_data_o     <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= last_bit;
            if (last_bit) begin
                deser_data_o <= {shift_q[DATA_W-2:0], ser_data_i};
            end
        end
    end

endmodule
